// File: rtl/wait_event_ctrl.sv
// wait_event_ctrl
// Runs one WAIT command at a time against a bank of single-bit wait lines.
// A command names a line, an event type and a cycle budget. The controller
// ends each accepted command with exactly one outcome: done, timeout, abort
// or bad index. All outcome pulses and status outputs are registered.

module wait_event_ctrl #(
    parameter int ALIAS_NB      = 5,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int SEL_WIDTH     = (ALIAS_NB > 1) ? $clog2(ALIAS_NB) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [SEL_WIDTH-1:0]     i_cmd_sel,
    input  logic [1:0]               i_cmd_type,
    input  logic [TIMEOUT_WIDTH-1:0] i_cmd_timeout,
    input  logic                     i_abort,
    input  logic [ALIAS_NB-1:0]      i_wait,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_timeout,
    output logic                     o_err,
    output logic [TIMEOUT_WIDTH-1:0] o_elapsed,
    output logic [1:0]               o_status
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] STAT_DONE    = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;
    localparam logic [1:0] STAT_ABORT   = 2'b11;

    localparam logic [1:0] EV_RISE  = 2'b00;
    localparam logic [1:0] EV_FALL  = 2'b01;
    localparam logic [1:0] EV_ANY   = 2'b10;
    localparam logic [1:0] EV_LEVEL = 2'b11;

    // Line count widened by one bit so an out-of-range index compares cleanly.
    localparam logic [SEL_WIDTH:0] LINE_COUNT = (SEL_WIDTH + 1)'(ALIAS_NB);

    state_t                   state_r;
    state_t                   next_state_s;
    logic [SEL_WIDTH-1:0]     sel_r;
    logic [1:0]               type_r;
    logic [TIMEOUT_WIDTH-1:0] timeout_r;
    logic [ALIAS_NB-1:0]      prev_r;
    logic [TIMEOUT_WIDTH-1:0] elapsed_r;
    logic [1:0]               status_r;
    logic                     done_r;
    logic                     timeout_pulse_r;
    logic                     err_r;

    logic                     accept_s;
    logic                     sel_ok_s;
    logic                     cur_s;
    logic                     prv_s;
    logic                     cond_s;
    logic [TIMEOUT_WIDTH:0]   elapsed_inc_s;
    logic [TIMEOUT_WIDTH-1:0] elapsed_sat_s;
    logic                     timeout_hit_s;
    logic                     done_nxt_s;
    logic                     timeout_nxt_s;
    logic                     err_nxt_s;
    logic [1:0]               status_nxt_s;
    logic [TIMEOUT_WIDTH-1:0] elapsed_nxt_s;

    assign accept_s = i_cmd_valid && (state_r == ST_IDLE);
    assign sel_ok_s = ({1'b0, i_cmd_sel} < LINE_COUNT);

    // Select the current and previous sample of the watched line.
    always_comb begin
        cur_s = 1'b0;
        prv_s = 1'b0;
        for (int i = 0; i < ALIAS_NB; i++) begin
            cur_s = cur_s | (i_wait[i] & (sel_r == SEL_WIDTH'(i)));
            prv_s = prv_s | (prev_r[i] & (sel_r == SEL_WIDTH'(i)));
        end
    end

    // Decode the event condition for the latched event type.
    always_comb begin
        cond_s = 1'b0;
        case (type_r)
            EV_RISE:  cond_s = cur_s & ~prv_s;
            EV_FALL:  cond_s = ~cur_s & prv_s;
            EV_ANY:   cond_s = cur_s ^ prv_s;
            EV_LEVEL: cond_s = cur_s;
            default:  cond_s = 1'b0;
        endcase
    end

    // Elapsed counter arithmetic; the extra bit keeps a saturated count from
    // ever matching a budget.
    assign elapsed_inc_s = {1'b0, elapsed_r} + {{TIMEOUT_WIDTH{1'b0}}, 1'b1};
    assign elapsed_sat_s = (&elapsed_r) ? elapsed_r : elapsed_inc_s[TIMEOUT_WIDTH-1:0];
    assign timeout_hit_s = (timeout_r != {TIMEOUT_WIDTH{1'b0}}) &&
                           (elapsed_inc_s == {1'b0, timeout_r});

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: abort, condition and timeout all end a wait.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && sel_ok_s) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (i_abort || cond_s || timeout_hit_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outcome outputs, with
    // abort beating condition and condition beating timeout.
    always_comb begin
        done_nxt_s    = 1'b0;
        timeout_nxt_s = 1'b0;
        err_nxt_s     = 1'b0;
        status_nxt_s  = status_r;
        elapsed_nxt_s = elapsed_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    elapsed_nxt_s = {TIMEOUT_WIDTH{1'b0}};
                    if (!sel_ok_s) begin
                        err_nxt_s    = 1'b1;
                        status_nxt_s = STAT_ABORT;
                    end else begin
                        err_nxt_s    = 1'b0;
                    end
                end else begin
                    elapsed_nxt_s = elapsed_r;
                end
            end
            ST_WAIT: begin
                elapsed_nxt_s = elapsed_sat_s;
                if (i_abort) begin
                    status_nxt_s = STAT_ABORT;
                end else if (cond_s) begin
                    done_nxt_s   = 1'b1;
                    status_nxt_s = STAT_DONE;
                end else if (timeout_hit_s) begin
                    timeout_nxt_s = 1'b1;
                    status_nxt_s  = STAT_TIMEOUT;
                end else begin
                    status_nxt_s = status_r;
                end
            end
            default: begin
                status_nxt_s = status_r;
            end
        endcase
    end

    // Outcome and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r          <= 1'b0;
            timeout_pulse_r <= 1'b0;
            err_r           <= 1'b0;
            status_r        <= 2'b00;
            elapsed_r       <= {TIMEOUT_WIDTH{1'b0}};
        end else begin
            done_r          <= done_nxt_s;
            timeout_pulse_r <= timeout_nxt_s;
            err_r           <= err_nxt_s;
            status_r        <= status_nxt_s;
            elapsed_r       <= elapsed_nxt_s;
        end
    end

    // Command fields are captured at acceptance and held for the whole wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_r     <= {SEL_WIDTH{1'b0}};
            type_r    <= 2'b00;
            timeout_r <= {TIMEOUT_WIDTH{1'b0}};
        end else if (accept_s) begin
            sel_r     <= i_cmd_sel;
            type_r    <= i_cmd_type;
            timeout_r <= i_cmd_timeout;
        end
    end

    // Previous line samples, taken every cycle so an edge before acceptance
    // is never seen as new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= {ALIAS_NB{1'b0}};
        end else begin
            prev_r <= i_wait;
        end
    end

    assign o_cmd_ready = (state_r == ST_IDLE);
    assign o_busy      = (state_r == ST_WAIT);
    assign o_done      = done_r;
    assign o_timeout   = timeout_pulse_r;
    assign o_err       = err_r;
    assign o_elapsed   = elapsed_r;
    assign o_status    = status_r;

endmodule

// File: tb/tb_wait_event_ctrl.sv
// Testbench for wait_event_ctrl: directed commands push their expected
// outcome into a queue; a monitor pops and compares on every outcome pulse.

module tb_wait_event_ctrl;

    localparam int NB = 5;
    localparam int TW = 32;
    localparam int SW = 3;

    localparam logic [2:0] K_DONE = 3'b100;
    localparam logic [2:0] K_TO   = 3'b010;
    localparam logic [2:0] K_ERR  = 3'b001;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] elapsed;
        logic [1:0]  status;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [SW-1:0] cmd_sel;
    logic [1:0]    cmd_type;
    logic [TW-1:0] cmd_timeout;
    logic          abort;
    logic [NB-1:0] wait_l;
    logic          busy;
    logic          done;
    logic          tmo;
    logic          err;
    logic [TW-1:0] elapsed;
    logic [1:0]    status;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;

    wait_event_ctrl #(.ALIAS_NB(NB), .TIMEOUT_WIDTH(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_sel    (cmd_sel),
        .i_cmd_type   (cmd_type),
        .i_cmd_timeout(cmd_timeout),
        .i_abort      (abort),
        .i_wait       (wait_l),
        .o_busy       (busy),
        .o_done       (done),
        .o_timeout    (tmo),
        .o_err        (err),
        .o_elapsed    (elapsed),
        .o_status     (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input logic [2:0] k, input logic [31:0] el, input logic [1:0] st);
        exp_t e;
        e.kind = k;
        e.elapsed = el;
        e.status = st;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [SW-1:0] s, input logic [1:0] t, input logic [TW-1:0] to);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_sel = s;
        cmd_type = t;
        cmd_timeout = to;
        chk("ready_before_accept", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d outcomes still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every outcome pulse must match the oldest expected outcome.
    always @(negedge clk) begin
        if (!rst && (done || tmo || err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pulse: got done/timeout/err=%b%b%b elapsed=%0d, expected none",
                         done, tmo, err, elapsed);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_kind", {29'b0, done, tmo, err}, {29'b0, mon_e.kind});
                chk("pulse_elapsed", elapsed, mon_e.elapsed);
                chk("pulse_status", {30'b0, status}, {30'b0, mon_e.status});
            end
        end
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_sel = '0;
        cmd_type = 2'b00;
        cmd_timeout = '0;
        abort = 1'b0;
        wait_l = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'b0, cmd_ready}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_elapsed", elapsed, 32'd0);
        chk("reset_status", {30'b0, status}, 32'd0);
        rst = 1'b0;

        // Rising edge on line 2 between T3 and T4, no budget.
        expect_pulse(K_DONE, 32'd4, 2'b01);
        issue(3'd2, 2'b00, 32'd0);
        repeat (3) @(posedge clk);
        #1 wait_l[2] = 1'b1;
        drain();
        @(negedge clk);
        chk("t1_idle_busy", {31'b0, busy}, 32'd0);
        wait_l[2] = 1'b0;

        // Level high on a line already high: done after T1.
        wait_l[0] = 1'b1;
        expect_pulse(K_DONE, 32'd1, 2'b01);
        issue(3'd0, 2'b11, 32'd0);
        drain();

        // Rising edge on the same still-high line needs a fresh edge.
        expect_pulse(K_DONE, 32'd4, 2'b01);
        issue(3'd0, 2'b00, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 wait_l[0] = 1'b0;
        chk("rise_no_stale_edge_busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1 wait_l[0] = 1'b1;
        drain();

        // Falling edge, budget 10, line never falls.
        wait_l[1] = 1'b1;
        expect_pulse(K_TO, 32'd10, 2'b10);
        issue(3'd1, 2'b01, 32'd10);
        drain();

        // Falling edge exactly at T10 beats the timeout.
        expect_pulse(K_DONE, 32'd10, 2'b01);
        issue(3'd1, 2'b01, 32'd10);
        repeat (9) @(posedge clk);
        #1 wait_l[1] = 1'b0;
        drain();
        wait_l[1] = 1'b1;

        // Out-of-range index.
        expect_pulse(K_ERR, 32'd0, 2'b11);
        issue(3'd7, 2'b00, 32'd0);
        @(negedge clk);
        chk("err_busy", {31'b0, busy}, 32'd0);
        chk("err_ready", {31'b0, cmd_ready}, 32'd1);
        drain();

        // Abort at T5 together with a rising edge: abort wins, no pulse.
        wait_l[3] = 1'b0;
        issue(3'd3, 2'b00, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        wait_l[3] = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_status", {30'b0, status}, 32'd3);
        chk("abort_elapsed", elapsed, 32'd5);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        // Abort while idle changes nothing.
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_status", {30'b0, status}, 32'd3);
        chk("idle_abort_elapsed", elapsed, 32'd5);

        // Back-to-back with valid held high; other lines toggle meanwhile.
        wait_l[4] = 1'b1;
        expect_pulse(K_DONE, 32'd1, 2'b01);
        expect_pulse(K_TO, 32'd3, 2'b10);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_sel = 3'd4;
        cmd_type = 2'b11;
        cmd_timeout = 32'd0;
        @(posedge clk);
        #1;
        cmd_sel = 3'd4;
        cmd_type = 2'b10;
        cmd_timeout = 32'd3;
        @(posedge clk);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_l[3:0] = ~wait_l[3:0];
        @(negedge clk);
        chk("b2b_second_busy", {31'b0, busy}, 32'd1);
        chk("b2b_second_ready", {31'b0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1 wait_l[3:0] = ~wait_l[3:0];
        drain();

        // Asynchronous reset mid-wait drops the command silently.
        wait_l[2] = 1'b0;
        issue(3'd2, 2'b00, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_elapsed", elapsed, 32'd0);
        chk("rst_status", {30'b0, status}, 32'd0);
        chk("rst_pulses", {29'b0, done, tmo, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_l[2] = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
